// File: rtl/whackamole_core.sv
// Whack-a-mole game engine: synchronised switch edges whack LFSR-spawned moles
// on a tick-driven timeline, with score, miss and time bookkeeping.
module whackamole_core #(
  parameter int N_HOLES    = 8,
  parameter int TICK_DIV   = 50000000,
  parameter int MOLE_LIFE  = 3,
  parameter int GAME_TICKS = 60,
  parameter int MAX_MISSES = 5,
  parameter int SCORE_W    = 10,
  parameter int PENALTY    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_HOLES-1:0] sw,
  output logic [N_HOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic [7:0]         time_left,
  output logic [1:0]         state,
  output logic               hit_pulse
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(N_HOLES + 1);
  localparam int XW = SCORE_W + CW + 1;
  localparam logic [XW-1:0] SCORE_MAX = {{(XW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  logic [N_HOLES-1:0] sw_s1_reg, sw_s2_reg, sw_s3_reg, whack_reg;
  logic [TW-1:0]      tick_cnt_reg;
  logic [15:0]        lfsr_reg, lfsr_next;
  logic [1:0]         state_reg;
  logic [N_HOLES-1:0] mole_reg, mole_next;
  logic [3:0]         life_reg  [N_HOLES];
  logic [3:0]         life_next [N_HOLES];
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [3:0]         misses_reg, misses_next;
  logic [7:0]         time_reg, time_next;
  logic               hit_pulse_reg;

  logic               play, tick, clear_all, game_end;
  logic [3:0]         spawn_idx;
  logic [N_HOLES-1:0] hit, dark, spawn, expire;
  logic [CW-1:0]      hit_cnt, dark_cnt, exp_cnt;
  logic [XW-1:0]      score_sum, score_pen;
  logic [5:0]         miss_sum;

  assign play      = (state_reg == ST_PLAY);
  assign tick      = play && (tick_cnt_reg == TW'(TICK_DIV - 1));
  assign spawn_idx = lfsr_reg[3:0];
  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

  // A hole index at or above N_HOLES never matches any gi, so it simply spawns nothing.
  generate
    for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_hole
      assign hit[gi]    = play && whack_reg[gi] && mole_reg[gi];
      assign dark[gi]   = play && whack_reg[gi] && !mole_reg[gi];
      assign spawn[gi]  = tick && (spawn_idx == 4'(gi)) && !mole_reg[gi];
      assign expire[gi] = tick && mole_reg[gi] && (life_reg[gi] == 4'd1) && !hit[gi];

      assign mole_next[gi] = clear_all     ? 1'b0 :
                             hit[gi]       ? 1'b0 :
                             spawn[gi]     ? 1'b1 :
                             expire[gi]    ? 1'b0 : mole_reg[gi];

      assign life_next[gi] = (clear_all || hit[gi]) ? 4'd0 :
                             spawn[gi]              ? 4'(MOLE_LIFE) :
                             (tick && mole_reg[gi]) ? life_reg[gi] - 4'd1 : life_reg[gi];
    end
  endgenerate

  always_comb begin
    hit_cnt  = '0;
    dark_cnt = '0;
    exp_cnt  = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      hit_cnt  = hit_cnt + CW'(hit[i]);
      dark_cnt = dark_cnt + CW'(dark[i]);
      exp_cnt  = exp_cnt + CW'(expire[i]);
    end
  end

  // Hits and penalties are summed in a wider word so the clamp sees the true result.
  always_comb begin
    score_sum = XW'(score_reg) + XW'(hit_cnt);
    score_pen = (PENALTY != 0) ? XW'(dark_cnt) : '0;
    if (score_sum < score_pen)
      score_next = '0;
    else if ((score_sum - score_pen) > SCORE_MAX)
      score_next = '1;
    else
      score_next = SCORE_W'(score_sum - score_pen);
  end

  assign miss_sum    = 6'(misses_reg) + 6'(exp_cnt);
  assign misses_next = (miss_sum > 6'd15) ? 4'd15 : miss_sum[3:0];
  assign time_next   = tick ? time_reg - 8'd1 : time_reg;
  assign game_end    = play && ((time_next == 8'd0) || (misses_next >= 4'(MAX_MISSES)));
  assign clear_all   = !play || game_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1_reg     <= '0;
      sw_s2_reg     <= '0;
      sw_s3_reg     <= '0;
      whack_reg     <= '0;
      tick_cnt_reg  <= '0;
      lfsr_reg      <= 16'hACE1;
      state_reg     <= ST_IDLE;
      mole_reg      <= '0;
      for (int i = 0; i < N_HOLES; i++) life_reg[i] <= 4'd0;
      score_reg     <= '0;
      misses_reg    <= 4'd0;
      time_reg      <= 8'd0;
      hit_pulse_reg <= 1'b0;
    end else begin
      sw_s1_reg <= sw;
      sw_s2_reg <= sw_s1_reg;
      sw_s3_reg <= sw_s2_reg;
      whack_reg <= sw_s2_reg ^ sw_s3_reg;
      lfsr_reg  <= lfsr_next;
      mole_reg  <= mole_next;
      life_reg  <= life_next;
      case (state_reg)
        ST_IDLE: begin
          hit_pulse_reg <= 1'b0;
          if (start) begin
            state_reg    <= ST_PLAY;
            score_reg    <= '0;
            misses_reg   <= 4'd0;
            time_reg     <= 8'(GAME_TICKS);
            tick_cnt_reg <= '0;
          end
        end
        ST_PLAY: begin
          score_reg     <= score_next;
          misses_reg    <= misses_next;
          time_reg      <= time_next;
          hit_pulse_reg <= |hit;
          tick_cnt_reg  <= tick ? '0 : tick_cnt_reg + TW'(1);
          if (game_end) state_reg <= ST_OVER;
        end
        ST_OVER: begin
          hit_pulse_reg <= 1'b0;
          if (start) state_reg <= ST_IDLE;
        end
        default: begin
          hit_pulse_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mole      = mole_reg;
  assign score     = score_reg;
  assign misses    = misses_reg;
  assign time_left = time_reg;
  assign state     = state_reg;
  assign hit_pulse = hit_pulse_reg;

endmodule
